regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_scoreboard.sv | 40 ++++
 rtl/regfile_mp.sv | 96 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the multi-port register file with issue scoreboard.
package rf_pkg;

    localparam int unsigned DEF_A_WIDTH = 5;
    localparam int unsigned DEF_D_WIDTH = 32;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_S1   = 9;
    localparam int unsigned REG_A0   = 10;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits: set on issue, cleared on writeback, set wins.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned A_WIDTH = DEF_A_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_en,
    input  logic [A_WIDTH-1:0] set_addr,
    input  logic               clr_en,
    input  logic [A_WIDTH-1:0] clr_addr,
    input  logic [A_WIDTH-1:0] q1_addr,
    input  logic [A_WIDTH-1:0] q2_addr,
    output logic               q1_busy,
    output logic               q2_busy
);

    localparam int unsigned DEPTH = 2 ** A_WIDTH;

    logic [DEPTH-1:0] busy;

    // Set is applied after clear so a new producer stays outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (clr_en && (clr_addr != A_WIDTH'(REG_ZERO))) begin
                busy[clr_addr] <= 1'b0;
            end
            if (set_en && (set_addr != A_WIDTH'(REG_ZERO))) begin
                busy[set_addr] <= 1'b1;
            end
        end
    end

    assign q1_busy = busy[q1_addr];
    assign q2_busy = busy[q2_addr];

endmodule

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with trigger load and issue scoreboard.
// Optional same-cycle write-to-read bypass enabled by defining RF_BYPASS_EN.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned A_WIDTH  = DEF_A_WIDTH,
    parameter int unsigned D_WIDTH  = DEF_D_WIDTH,
    parameter int unsigned TRIG_REG = REG_S1,
    parameter int unsigned TRIG_VAL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [A_WIDTH-1:0] ad1,
    input  logic [A_WIDTH-1:0] ad2,
    output logic [D_WIDTH-1:0] rd1,
    output logic [D_WIDTH-1:0] rd2,
    input  logic               we3,
    input  logic [A_WIDTH-1:0] ad3,
    input  logic [D_WIDTH-1:0] wd3,
    input  logic               issue_valid,
    input  logic [A_WIDTH-1:0] issue_rd,
    output logic               rs1_busy,
    output logic               rs2_busy,
    output logic               hazard,
    input  logic               trigger,
    output logic [D_WIDTH-1:0] a0
);

    localparam int unsigned DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH-1:0] ZERO_ADDR = A_WIDTH'(REG_ZERO);
    localparam logic [A_WIDTH-1:0] TRIG_ADDR = A_WIDTH'(TRIG_REG);

    logic [D_WIDTH-1:0] regs [DEPTH];
    logic               wr_en;
    logic               q1_busy;
    logic               q2_busy;

    assign wr_en = rst_n && we3 && (ad3 != ZERO_ADDR);

    // Writeback is applied after trigger so we3 data wins on a collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (trigger && (TRIG_ADDR != ZERO_ADDR)) begin
                regs[TRIG_ADDR] <= D_WIDTH'(TRIG_VAL);
            end
            if (wr_en) begin
                regs[ad3] <= wd3;
            end
        end
    end

    rf_scoreboard #(
        .A_WIDTH (A_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue_valid),
        .set_addr (issue_rd),
        .clr_en   (we3),
        .clr_addr (ad3),
        .q1_addr  (ad1),
        .q2_addr  (ad2),
        .q1_busy  (q1_busy),
        .q2_busy  (q2_busy)
    );

    // Read ports; register 0 is forced to zero regardless of array contents.
    always_comb begin
        rd1      = (ad1 == ZERO_ADDR) ? '0 : regs[ad1];
        rd2      = (ad2 == ZERO_ADDR) ? '0 : regs[ad2];
        rs1_busy = q1_busy;
        rs2_busy = q2_busy;
`ifdef RF_BYPASS_EN
        if (wr_en && (ad3 == ad1)) begin
            rd1 = wd3;
            if (!(issue_valid && (issue_rd == ad1))) begin
                rs1_busy = 1'b0;
            end
        end
        if (wr_en && (ad3 == ad2)) begin
            rd2 = wd3;
            if (!(issue_valid && (issue_rd == ad2))) begin
                rs2_busy = 1'b0;
            end
        end
`endif
    end

    assign hazard = rs1_busy | rs2_busy;
    assign a0     = regs[A_WIDTH'(REG_A0)];

endmodule
